// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bus bundle: memory request/response, redirect and decode handoff.
// master = fetch unit, slave = memory/pipeline environment.
interface mips_fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_resp_valid_i;
  logic [DATA_WIDTH-1:0] imem_resp_data_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  id_valid_o;
  logic                  id_ready_i;
  logic [DATA_WIDTH-1:0] id_instr_o;
  logic [ADDR_WIDTH-1:0] id_pc_plus_4_o;
  logic [OW-1:0]         occupancy_o;

  modport master (
    output imem_req_valid_o, imem_addr_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    input  redirect_i, redirect_pc_i, id_ready_i,
    output id_valid_o, id_instr_o, id_pc_plus_4_o, occupancy_o
  );

  modport slave (
    input  imem_req_valid_o, imem_addr_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    output redirect_i, redirect_pc_i, id_ready_i,
    input  id_valid_o, id_instr_o, id_pc_plus_4_o, occupancy_o
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS fetch front end: PC, credit-limited fetch issue, response FIFO, redirect flush.
// Optional FETCH_BYPASS_EN: empty-FIFO responses go straight to decode.
module mips_fetch_queue #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               reset,
  mips_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc4;
  } entry_t;

  logic                  run_q, run_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [OW-1:0]         wr_q, wr_d;
  logic [OW-1:0]         rd_q, rd_d;
  logic [TW-1:0]         tag_wr_q, tag_wr_d;
  logic [TW-1:0]         tag_rd_q, tag_rd_d;
  logic [ADDR_WIDTH-1:0] tag_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] tag_d [MAX_OUTSTANDING];
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  entry_t                hold_q, hold_d;

  logic [OW-1:0]         occ;
  logic                  empty;
  logic                  resp_ok;
  logic                  req_valid;
  logic                  fire;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  entry_t                head;
  entry_t                shown;
  logic [ADDR_WIDTH-1:0] tag_head;
  logic                  unused;

  assign unused = ^bus.redirect_pc_i[1:0];

  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] i);
    return (int'(i) == MAX_OUTSTANDING - 1) ? '0 : i + TW'(1);
  endfunction

  // Issue credit, response routing and decode-side head selection
  always_comb begin
    occ      = wr_q - rd_q;
    empty    = (occ == '0);
    head     = mem_q[rd_q[PW-1:0]];
    tag_head = tag_q[tag_rd_q];
    resp_ok  = bus.imem_resp_valid_i && (out_q != '0);
    req_valid = run_q && !bus.redirect_i
              && (int'(out_q) < MAX_OUTSTANDING)
              && (int'(occ) + int'(out_q) < DEPTH);
    fire = req_valid && bus.imem_req_ready_i;
`ifdef FETCH_BYPASS_EN
    bypass = empty && (drop_q == '0) && resp_ok
           && bus.id_ready_i && !bus.redirect_i;
`else
    bypass = 1'b0;
`endif
    push = resp_ok && (drop_q == '0) && !bus.redirect_i && !bypass;
    pop  = !empty && bus.id_ready_i;

    shown          = hold_q;
    bus.id_valid_o = 1'b0;
    if (bypass) begin
      shown          = '{instr: bus.imem_resp_data_i, pc4: tag_head};
      bus.id_valid_o = 1'b1;
    end else if (!empty) begin
      shown          = head;
      bus.id_valid_o = 1'b1;
    end
    bus.id_instr_o       = shown.instr;
    bus.id_pc_plus_4_o   = shown.pc4;
    bus.imem_req_valid_o = req_valid;
    bus.imem_addr_o      = pc_q;
    bus.occupancy_o      = occ;
  end

  // Next-state for PC, credit counters, tag queue and FIFO
  always_comb begin
    run_d    = 1'b1;
    pc_d     = pc_q;
    out_d    = out_q + CW'(fire) - CW'(resp_ok);
    drop_d   = drop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    tag_d    = tag_q;
    mem_d    = mem_q;
    hold_d   = (bypass || !empty) ? shown : hold_q;

    if (fire) begin
      pc_d            = pc_q + ADDR_WIDTH'(4);
      tag_d[tag_wr_q] = pc_q + ADDR_WIDTH'(4);
      tag_wr_d        = tinc(tag_wr_q);
    end
    if (resp_ok) begin
      tag_rd_d = tinc(tag_rd_q);
      if (drop_q != '0) drop_d = drop_q - CW'(1);
    end
    if (push) begin
      mem_d[wr_q[PW-1:0]] = '{instr: bus.imem_resp_data_i, pc4: tag_head};
      wr_d = wr_q + OW'(1);
    end
    if (pop) rd_d = rd_q + OW'(1);

    if (bus.redirect_i) begin
      pc_d   = {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      drop_d = out_q - CW'(resp_ok);
      rd_d   = wr_q;
      wr_d   = wr_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      hold_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      run_q    <= run_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      hold_q   <= hold_d;
      tag_q    <= tag_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue with an in-order memory model.
// Inputs change at posedge+2, checks at posedge+3.
module tb_mips_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_fetch_queue_if bus();
  mips_fetch_queue dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n_fire = 0;
  int base;
  logic resp_en = 1'b1;
  logic [31:0] q[$];

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      bus.imem_resp_valid_i <= 1'b0;
      bus.imem_resp_data_i  <= '0;
    end else begin
      if (bus.imem_resp_valid_i) void'(q.pop_front());
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        q.push_back(bus.imem_addr_o);
        n_fire <= n_fire + 1;
      end
      bus.imem_resp_valid_i <= resp_en && (q.size() > 0);
      bus.imem_resp_data_i  <= (q.size() > 0) ? mk(q[0]) : '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rv"},   32'(bus.imem_req_valid_o), 32'h0);
    chk({tag, "_addr"}, bus.imem_addr_o, 32'h0);
    chk({tag, "_idv"},  32'(bus.id_valid_o), 32'h0);
    chk({tag, "_ins"},  bus.id_instr_o, 32'h0);
    chk({tag, "_pc4"},  bus.id_pc_plus_4_o, 32'h0);
    chk({tag, "_occ"},  32'(bus.occupancy_o), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    bus.imem_req_ready_i = 1'b1;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.id_ready_i       = 1'b1;

    // Reset values and streaming fetch
    #1;
    chk_reset_vals("rst0");
    do_reset();
    chk("s_a_rv", 32'(bus.imem_req_valid_o), 32'h0);
    tick(); #1;
    chk("s_b_rv", 32'(bus.imem_req_valid_o), 32'h1);
    chk("s_b_addr", bus.imem_addr_o, 32'h0);
    tick(); #1;
    chk("s_c_addr", bus.imem_addr_o, 32'h4);
    chk("s_c_idv", 32'(bus.id_valid_o), 32'h0);
    tick(); #1;
    chk("s_d_idv", 32'(bus.id_valid_o), 32'h1);
    chk("s_d_pc4", bus.id_pc_plus_4_o, 32'h4);
    chk("s_d_ins", bus.id_instr_o, mk(32'h0));
    chk("s_d_occ", 32'(bus.occupancy_o), 32'h1);
    chk("s_d_addr", bus.imem_addr_o, 32'h8);
    tick(); #1;
    chk("s_e_pc4", bus.id_pc_plus_4_o, 32'h8);
    tick(); #1;
    chk("s_f_pc4", bus.id_pc_plus_4_o, 32'hC);

    // Decode stalled: fill to DEPTH
    bus.id_ready_i = 1'b0;
    do_reset();
    base = n_fire;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("full_fires", 32'(n_fire - base), 32'd4);
    chk("full_occ", 32'(bus.occupancy_o), 32'd4);
    chk("full_rv", 32'(bus.imem_req_valid_o), 32'h0);
    chk("full_pc4", bus.id_pc_plus_4_o, 32'h4);
    bus.id_ready_i = 1'b1;
    tick();
    bus.id_ready_i = 1'b0;
    #1;
    chk("pop_occ", 32'(bus.occupancy_o), 32'd3);
    chk("pop_rv", 32'(bus.imem_req_valid_o), 32'h1);
    chk("pop_addr", bus.imem_addr_o, 32'h10);
    chk("pop_pc4", bus.id_pc_plus_4_o, 32'h8);

    // Redirect with two outstanding requests
    bus.id_ready_i = 1'b1;
    resp_en = 1'b0;
    do_reset();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h10;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("rd_b_addr", bus.imem_addr_o, 32'h10);
    chk("rd_b_rv", 32'(bus.imem_req_valid_o), 32'h1);
    tick(); #1;
    chk("rd_c_addr", bus.imem_addr_o, 32'h14);
    tick();
    resp_en = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    #1;
    chk("rd_d_rv", 32'(bus.imem_req_valid_o), 32'h0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("rd_e_rv", 32'(bus.imem_req_valid_o), 32'h0);
    chk("rd_e_idv", 32'(bus.id_valid_o), 32'h0);
    tick(); #1;
    chk("rd_f_rv", 32'(bus.imem_req_valid_o), 32'h1);
    chk("rd_f_addr", bus.imem_addr_o, 32'h100);
    chk("rd_f_idv", 32'(bus.id_valid_o), 32'h0);
    tick(); #1;
    chk("rd_g_idv", 32'(bus.id_valid_o), 32'h0);
    chk("rd_g_addr", bus.imem_addr_o, 32'h104);
    tick(); #1;
    chk("rd_h_idv", 32'(bus.id_valid_o), 32'h1);
    chk("rd_h_pc4", bus.id_pc_plus_4_o, 32'h104);
    chk("rd_h_ins", bus.id_instr_o, mk(32'h100));

    // Memory not ready for three cycles
    do_reset();
    bus.imem_req_ready_i = 1'b0;
    tick(); #1;
    base = n_fire;
    chk("nr_b_addr", bus.imem_addr_o, 32'h0);
    tick(); #1;
    chk("nr_c_addr", bus.imem_addr_o, 32'h0);
    tick(); #1;
    chk("nr_d_addr", bus.imem_addr_o, 32'h0);
    chk("nr_d_rv", 32'(bus.imem_req_valid_o), 32'h1);
    bus.imem_req_ready_i = 1'b1;
    tick(); #1;
    chk("nr_e_addr", bus.imem_addr_o, 32'h4);
    chk("nr_e_fires", 32'(n_fire - base), 32'd1);

    // Redirect together with a pop and a response
    bus.id_ready_i = 1'b0;
    do_reset();
    tick(); tick(); tick();
    bus.id_ready_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h40;
    #1;
    chk("rp_d_idv", 32'(bus.id_valid_o), 32'h1);
    chk("rp_d_pc4", bus.id_pc_plus_4_o, 32'h4);
    chk("rp_d_resp", 32'(bus.imem_resp_valid_i), 32'h1);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("rp_e_occ", 32'(bus.occupancy_o), 32'h0);
    chk("rp_e_idv", 32'(bus.id_valid_o), 32'h0);
    chk("rp_e_hold_pc4", bus.id_pc_plus_4_o, 32'h4);
    chk("rp_e_hold_ins", bus.id_instr_o, mk(32'h0));
    chk("rp_e_addr", bus.imem_addr_o, 32'h40);
    tick(); tick(); #1;
    chk("rp_g_idv", 32'(bus.id_valid_o), 32'h1);
    chk("rp_g_pc4", bus.id_pc_plus_4_o, 32'h44);

    // Reset mid-operation with requests in flight and entries queued
    bus.id_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("mr_occ_pre", 32'(bus.occupancy_o), 32'd3);
    reset = 1'b0;
    #1;
    chk_reset_vals("mr");
    tick();
    tick();
    reset = 1'b1;
    bus.id_ready_i = 1'b1;
    #1;
    chk("mr_a_occ", 32'(bus.occupancy_o), 32'h0);
    tick(); #1;
    chk("mr_b_rv", 32'(bus.imem_req_valid_o), 32'h1);
    chk("mr_b_addr", bus.imem_addr_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
